// File: rtl/acc_block_mc.sv
// rtl/acc_block_mc.sv - multi-channel LEN-beat block accumulator with valid/ready result register
// Optional saturation with per-channel overflow flags when ACC_SAT_EN is defined.
module acc_block_mc #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 10,
  parameter int CH    = 2,
  parameter int LEN   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH*IN_W-1:0]  in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH*ACC_W-1:0] out_data,
  output logic [CH-1:0]       out_ovf
);

  localparam int CW = $clog2(LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  logic [CW-1:0]    cnt;
  logic [ACC_W-1:0] sum [CH];
  logic [ACC_W-1:0] nxt [CH];
  logic             accept;
  logic             blk_end;

  // Only the block-ending beat stalls, and only if it would overwrite an unconsumed result.
  assign in_ready = !rst && !clr && !((cnt == LAST) && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign blk_end  = accept && (cnt == LAST);

`ifdef ACC_SAT_EN
  logic [ACC_W:0]   wide [CH];
  logic [CH-1:0]    carry;
  logic [CH-1:0]    sticky;

  // A clamped sum plus any non-zero sample carries out again, so it stays clamped.
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      wide[c]  = {1'b0, sum[c]} + (ACC_W+1)'(in_data[c*IN_W +: IN_W]);
      carry[c] = wide[c][ACC_W];
      nxt[c]   = carry[c] ? {ACC_W{1'b1}} : wide[c][ACC_W-1:0];
    end
  end
`else
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      nxt[c] = sum[c] + ACC_W'(in_data[c*IN_W +: IN_W]);
    end
  end

  assign out_ovf = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int c = 0; c < CH; c++) sum[c] <= '0;
`ifdef ACC_SAT_EN
      out_ovf   <= '0;
      sticky    <= '0;
`endif
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (clr) begin
        cnt <= '0;
        for (int c = 0; c < CH; c++) sum[c] <= '0;
`ifdef ACC_SAT_EN
        sticky <= '0;
`endif
      end else if (blk_end) begin
        cnt       <= '0;
        out_valid <= 1'b1;
        for (int c = 0; c < CH; c++) begin
          out_data[c*ACC_W +: ACC_W] <= nxt[c];
          sum[c]                     <= '0;
        end
`ifdef ACC_SAT_EN
        out_ovf <= sticky | carry;
        sticky  <= '0;
`endif
      end else if (accept) begin
        cnt <= cnt + 1'b1;
        for (int c = 0; c < CH; c++) sum[c] <= nxt[c];
`ifdef ACC_SAT_EN
        sticky <= sticky | carry;
`endif
      end
    end
  end

endmodule

// File: tb/tb_acc_block_mc.sv
// tb/tb_acc_block_mc.sv - self-checking bench for acc_block_mc (LEN=4, LEN=8, LEN=1 instances)
module tb_acc_block_mc;

  localparam int IN_W  = 8;
  localparam int ACC_W = 10;
  localparam int CH    = 2;
  localparam int ACC_MAX = (1 << ACC_W) - 1;
`ifdef ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clr, out_ready;
  logic [CH*IN_W-1:0] in_data;
  logic v4, v8, v1;
  logic r4, r8, r1;
  logic ov4, ov8, ov1;
  logic [CH*ACC_W-1:0] d4, d8, d1;
  logic [CH-1:0] f4, f8, f1;

  int n_checks = 0;
  int n_fail   = 0;

  acc_block_mc #(.IN_W(IN_W), .ACC_W(ACC_W), .CH(CH), .LEN(4)) u_dut4 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(v4), .in_ready(r4), .in_data(in_data),
    .out_valid(ov4), .out_ready(out_ready), .out_data(d4), .out_ovf(f4));

  acc_block_mc #(.IN_W(IN_W), .ACC_W(ACC_W), .CH(CH), .LEN(8)) u_dut8 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(v8), .in_ready(r8), .in_data(in_data),
    .out_valid(ov8), .out_ready(out_ready), .out_data(d8), .out_ovf(f8));

  acc_block_mc #(.IN_W(IN_W), .ACC_W(ACC_W), .CH(CH), .LEN(1)) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(v1), .in_ready(r1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(d1), .out_ovf(f1));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int c0, input int c1);
    in_data = {IN_W'(c1), IN_W'(c0)};
  endtask

  task automatic do_reset;
    rst = 1'b1; clr = 1'b0; out_ready = 1'b1;
    v4 = 1'b0; v8 = 1'b0; v1 = 1'b0; in_data = '0;
    tick; tick;
    rst = 1'b0;
    tick;
  endtask

  function automatic int blk_result(input int total);
    if (SAT) return (total > ACC_MAX) ? ACC_MAX : total;
    return total % (ACC_MAX + 1);
  endfunction

  task automatic test_reset;
    rst = 1'b1; clr = 1'b0; out_ready = 1'b1;
    v4 = 1'b1; v8 = 1'b1; v1 = 1'b1; in_data = '1;
    tick;
    n_checks++; if ({ov4, ov8, ov1} !== 3'b000) begin n_fail++; $display("FAIL reset_valid: got %b expected 000", {ov4, ov8, ov1}); end
    n_checks++; if (d4 !== '0 || d8 !== '0 || d1 !== '0) begin n_fail++; $display("FAIL reset_data: got %h %h %h expected 0", d4, d8, d1); end
    n_checks++; if ({f4, f8, f1} !== '0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", {f4, f8, f1}); end
    n_checks++; if ({r4, r8, r1} !== 3'b000) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 000", {r4, r8, r1}); end
    do_reset;
  endtask

  task automatic test_basic;
    do_reset;
    v4 = 1'b1; set_in(5, 10);
    repeat (3) tick;
    n_checks++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b expected 0", ov4); end
    tick;
    v4 = 1'b0;
    n_checks++; if (ov4 !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", ov4); end
    n_checks++; if (d4[ACC_W-1:0] !== ACC_W'(20)) begin n_fail++; $display("FAIL basic_ch0: got %0d expected 20", d4[ACC_W-1:0]); end
    n_checks++; if (d4[2*ACC_W-1:ACC_W] !== ACC_W'(40)) begin n_fail++; $display("FAIL basic_ch1: got %0d expected 40", d4[2*ACC_W-1:ACC_W]); end
    n_checks++; if (f4 !== '0) begin n_fail++; $display("FAIL basic_ovf: got %b expected 00", f4); end
    tick;
    n_checks++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL basic_drop: got %b expected 0", ov4); end
  endtask

  task automatic test_backpressure;
    do_reset;
    out_ready = 1'b0; v4 = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      set_in(k, 0);
      if (k >= 5) begin
        n_checks++; if (r4 !== 1'b1) begin n_fail++; $display("FAIL bp_ready_beat%0d: got %b expected 1", k, r4); end
        n_checks++; if (ov4 !== 1'b1 || d4[ACC_W-1:0] !== ACC_W'(10)) begin n_fail++; $display("FAIL bp_hold_beat%0d: got v=%b d=%0d expected v=1 d=10", k, ov4, d4[ACC_W-1:0]); end
      end
      tick;
    end
    set_in(8, 0);
    for (int s = 0; s < 3; s++) begin
      n_checks++; if (r4 !== 1'b0) begin n_fail++; $display("FAIL bp_stall%0d: got in_ready=%b expected 0", s, r4); end
      n_checks++; if (ov4 !== 1'b1 || d4[ACC_W-1:0] !== ACC_W'(10)) begin n_fail++; $display("FAIL bp_stall_hold%0d: got v=%b d=%0d expected v=1 d=10", s, ov4, d4[ACC_W-1:0]); end
      tick;
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (r4 !== 1'b1) begin n_fail++; $display("FAIL bp_release: got in_ready=%b expected 1", r4); end
    tick;
    v4 = 1'b0;
    n_checks++; if (ov4 !== 1'b1 || d4[ACC_W-1:0] !== ACC_W'(26)) begin n_fail++; $display("FAIL bp_block2: got v=%b d=%0d expected v=1 d=26", ov4, d4[ACC_W-1:0]); end
    tick;
    n_checks++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL bp_drop: got %b expected 0", ov4); end
  endtask

  task automatic test_overflow;
    do_reset;
    v8 = 1'b1; set_in(255, 1);
    repeat (8) tick;
    v8 = 1'b0;
    n_checks++; if (ov8 !== 1'b1) begin n_fail++; $display("FAIL ovf_valid: got %b expected 1", ov8); end
    n_checks++; if (d8[ACC_W-1:0] !== ACC_W'(SAT ? 1023 : 1016)) begin n_fail++; $display("FAIL ovf_ch0: got %0d expected %0d", d8[ACC_W-1:0], SAT ? 1023 : 1016); end
    n_checks++; if (d8[2*ACC_W-1:ACC_W] !== ACC_W'(8)) begin n_fail++; $display("FAIL ovf_ch1: got %0d expected 8", d8[2*ACC_W-1:ACC_W]); end
    n_checks++; if (f8 !== (SAT ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL ovf_flag: got %b expected %b", f8, SAT ? 2'b01 : 2'b00); end
    tick;
  endtask

  task automatic test_clr;
    do_reset;
    v4 = 1'b1; set_in(7, 0);
    tick; tick;
    clr = 1'b1;
    #1;
    n_checks++; if (r4 !== 1'b0) begin n_fail++; $display("FAIL clr_ready: got %b expected 0", r4); end
    tick;
    clr = 1'b0; set_in(3, 0);
    repeat (4) tick;
    v4 = 1'b0;
    n_checks++; if (ov4 !== 1'b1 || d4[ACC_W-1:0] !== ACC_W'(12)) begin n_fail++; $display("FAIL clr_sum: got v=%b d=%0d expected v=1 d=12", ov4, d4[ACC_W-1:0]); end
    tick;
    out_ready = 1'b0; v4 = 1'b1; set_in(1, 2);
    repeat (4) tick;
    v4 = 1'b0; clr = 1'b1;
    tick;
    clr = 1'b0;
    n_checks++; if (ov4 !== 1'b1 || d4 !== {ACC_W'(8), ACC_W'(4)}) begin n_fail++; $display("FAIL clr_pending: got v=%b d=%h expected v=1 ch0=4 ch1=8", ov4, d4); end
    out_ready = 1'b1;
    tick;
    n_checks++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL clr_pending_drop: got %b expected 0", ov4); end
  endtask

  task automatic test_async_reset;
    do_reset;
    out_ready = 1'b0; v4 = 1'b1; set_in(1, 1);
    repeat (4) tick;
    set_in(9, 0);
    tick; tick;
    v4 = 1'b0;
    #3 rst = 1'b1;
    #1;
    n_checks++; if (ov4 !== 1'b0 || d4 !== '0 || r4 !== 1'b0) begin n_fail++; $display("FAIL arst_immediate: got v=%b d=%h rdy=%b expected 0 0 0", ov4, d4, r4); end
    #1 rst = 1'b0;
    out_ready = 1'b1;
    tick;
    v4 = 1'b1; set_in(2, 0);
    repeat (4) tick;
    v4 = 1'b0;
    n_checks++; if (ov4 !== 1'b1 || d4 !== {ACC_W'(0), ACC_W'(8)}) begin n_fail++; $display("FAIL arst_residue: got v=%b d=%h expected v=1 ch0=8 ch1=0", ov4, d4); end
    tick;
  endtask

  task automatic test_len1;
    do_reset;
    v1 = 1'b1;
    n_checks++; if (r1 !== 1'b1) begin n_fail++; $display("FAIL len1_ready: got %b expected 1", r1); end
    for (int k = 3; k <= 5; k++) begin
      set_in(k, 0);
      tick;
      n_checks++; if (ov1 !== 1'b1 || d1[ACC_W-1:0] !== ACC_W'(k)) begin n_fail++; $display("FAIL len1_beat%0d: got v=%b d=%0d expected v=1 d=%0d", k, ov1, d1[ACC_W-1:0], k); end
    end
    v1 = 1'b0;
    tick;
    n_checks++; if (ov1 !== 1'b0) begin n_fail++; $display("FAIL len1_drop: got %b expected 0", ov1); end
  endtask

  task automatic test_random;
    int blk0[$];
    int blk1[$];
    bit pend;
    int pd0, pd1, t0, t1;
    logic [CH-1:0] pf;
    logic exp_r;
    do_reset;
    pend = 1'b0; pd0 = 0; pd1 = 0; pf = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      n_checks++; if (ov4 !== pend) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b expected %b", cyc, ov4, pend); end
      if (pend) begin
        n_checks++;
        if (d4 !== {ACC_W'(pd1), ACC_W'(pd0)} || f4 !== pf) begin
          n_fail++; $display("FAIL rnd_data@%0d: got d=%h f=%b expected ch0=%0d ch1=%0d f=%b", cyc, d4, f4, pd0, pd1, pf);
        end
      end
      v4 = ($urandom_range(0, 3) != 0);
      out_ready = (cyc % 64 < 40) ? ($urandom_range(0, 2) != 0) : 1'b0;
      clr = ($urandom_range(0, 19) == 0);
      in_data = CH*IN_W'($urandom);
      #1;
      exp_r = !clr && !(blk0.size() == 3 && pend && !out_ready);
      n_checks++; if (r4 !== exp_r) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b expected %b", cyc, r4, exp_r); end
      if (pend && out_ready) pend = 1'b0;
      if (clr) begin
        blk0.delete(); blk1.delete();
      end else if (v4 && exp_r) begin
        blk0.push_back(int'(in_data[IN_W-1:0]));
        blk1.push_back(int'(in_data[2*IN_W-1:IN_W]));
        if (blk0.size() == 4) begin
          t0 = blk0.sum(); t1 = blk1.sum();
          pd0 = blk_result(t0); pd1 = blk_result(t1);
          pf = SAT ? {t1 > ACC_MAX, t0 > ACC_MAX} : 2'b00;
          pend = 1'b1;
          blk0.delete(); blk1.delete();
        end
      end
      tick;
    end
    v4 = 1'b0; clr = 1'b0; out_ready = 1'b1;
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_overflow;
    test_clr;
    test_async_reset;
    test_len1;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
